// File: rtl/icache_tag_pkg.sv
// Shared definitions for the instruction-cache tag controller: geometry,
// FSM state encoding, the stored tag-entry layout and address slicing.
package icache_tag_pkg;

  localparam int IDX_W      = 8;
  localparam int TAG_W      = 20;
  localparam int OFS_W      = 4;
  localparam int TAG_WORD_W = TAG_W + 1;

  typedef enum logic {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } state_e;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;

  // Set index of a fetch address.
  function automatic logic [IDX_W-1:0] idx_of(input logic [31:0] addr);
    return addr[OFS_W +: IDX_W];
  endfunction

  // Tag portion of a fetch address.
  function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] addr);
    return addr[OFS_W + IDX_W +: TAG_W];
  endfunction

endpackage

// File: rtl/icache_tag_sweep.sv
// Invalidate-sweep index counter: walks every set while active, flags the
// last index and emits a one-cycle done pulse in the cycle after it.
module icache_tag_sweep
  import icache_tag_pkg::*;
(
  input  logic             wr_clk,
  input  logic             tb_wr_rst,
  input  logic             active,
  output logic [IDX_W-1:0] idx,
  output logic             last,
  output logic             done
);

  assign last = active & (idx == '1);

  // Step the index while sweeping and register the completion pulse.
  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) begin
      idx  <= '0;
      done <= 1'b0;
    end else begin
      done <= last;
      if (active) idx <= idx + 1'b1;  // wraps to 0 after the last set
      else        idx <= '0;
    end
  end

endmodule

// File: rtl/icache_tag_ctrl.sv
// Tag RAM sequencer for the instruction cache. Owns both ports of the
// 256x21 SDP tag RAM: lookups on the read port (hit/miss one cycle after
// accept), line fills on the write port, and a full invalidate sweep after
// reset and on flush_req.
// Optional: define ICACHE_TAG_PERF_CNT_EN to add saturating hit/miss
// counters (perf_hit_cnt, perf_miss_cnt).
module icache_tag_ctrl
  import icache_tag_pkg::*;
(
  input  logic                  wr_clk,
  input  logic                  tb_wr_rst,
  input  logic                  lk_valid,
  output logic                  lk_ready,
  input  logic [31:0]           lk_addr,
  output logic                  lk_resp_valid,
  output logic                  lk_hit,
  input  logic                  fill_valid,
  output logic                  fill_ready,
  input  logic [31:0]           fill_addr,
  input  logic                  flush_req,
  output logic                  flush_busy,
  output logic                  flush_done,
  output logic                  tag_wr_en,
  output logic [IDX_W-1:0]      tag_wr_addr,
  output logic [TAG_WORD_W-1:0] tag_wr_data,
  output logic [IDX_W-1:0]      tag_rd_addr,
  input  logic [TAG_WORD_W-1:0] tag_rd_data
`ifdef ICACHE_TAG_PERF_CNT_EN
  ,
  output logic [31:0]           perf_hit_cnt,
  output logic [31:0]           perf_miss_cnt
`endif
);

  state_e           state;
  logic             in_idle;
  logic             lk_acc;
  logic             fill_acc;
  logic             enter_sweep;
  logic             sweep_wr;
  logic [IDX_W-1:0] sweep_idx;
  logic             sweep_last;
  logic             sweep_done;

  // Lookup pipeline registers (request cycle -> response cycle).
  logic             resp_valid_q;
  logic [TAG_W-1:0] lk_tag_q;
  logic             fwd_q;
  logic             fwd_hit_q;
  logic [IDX_W-1:0] rd_idx_q;
  tag_entry_t       ram_entry;
  tag_entry_t       fill_entry;

  // Offset bits select a byte within the line and are irrelevant to tags.
  logic unused_ofs;
  assign unused_ofs = ^{lk_addr[OFS_W-1:0], fill_addr[OFS_W-1:0]};

  assign in_idle     = (state == IDLE);
  assign lk_ready    = in_idle;
  assign fill_ready  = in_idle;
  assign flush_busy  = (state == SWEEP);
  assign flush_done  = sweep_done;
  assign lk_acc      = lk_valid & in_idle;
  assign fill_acc    = fill_valid & in_idle;
  assign enter_sweep = in_idle & flush_req;

  // The reset state is SWEEP, yet the write strobe must read 0 while reset
  // is held, so the sweep write is qualified by the reset input itself.
  assign sweep_wr = (state == SWEEP) & ~tb_wr_rst;

  icache_tag_sweep u_sweep (
    .wr_clk    (wr_clk),
    .tb_wr_rst (tb_wr_rst),
    .active    (state == SWEEP),
    .idx       (sweep_idx),
    .last      (sweep_last),
    .done      (sweep_done)
  );

  // Two-state sequencer: sweep until the last set is cleared, then serve
  // requests until a flush is requested. flush_req mid-sweep is ignored.
  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) begin
      state <= SWEEP;
    end else begin
      case (state)
        SWEEP:   if (sweep_last) state <= IDLE;
        IDLE:    if (flush_req)  state <= SWEEP;
        default: state <= SWEEP;
      endcase
    end
  end

  assign fill_entry = '{valid: 1'b1, tag: tag_of(fill_addr)};

  // Write port: sweep clears one set per cycle; in IDLE an accepted fill
  // writes a valid entry in the same cycle.
  // NOTE: every output gets a default before the branches so no latch is
  // inferred on paths that do not assign it.
  always_comb begin
    tag_wr_en   = 1'b0;
    tag_wr_addr = sweep_idx;
    tag_wr_data = '0;
    if (sweep_wr) begin
      tag_wr_en = 1'b1;
    end else if (fill_acc) begin
      tag_wr_en   = 1'b1;
      tag_wr_addr = idx_of(fill_addr);
      tag_wr_data = fill_entry;
    end
  end

  // Read index follows an accepted lookup, otherwise holds the last one.
  assign tag_rd_addr = lk_acc ? idx_of(lk_addr) : rd_idx_q;

  // Capture the lookup tag and, when a fill to the same set is accepted
  // alongside it, the fill-versus-lookup tag compare used instead of RAM.
  // NOTE: only control and pipeline flops are reset; the tag RAM is never
  // reset and is initialised solely by the sweep.
  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) begin
      resp_valid_q <= 1'b0;
      lk_tag_q     <= '0;
      fwd_q        <= 1'b0;
      fwd_hit_q    <= 1'b0;
      rd_idx_q     <= '0;
    end else begin
      resp_valid_q <= lk_acc;
      if (lk_acc) begin
        lk_tag_q  <= tag_of(lk_addr);
        rd_idx_q  <= idx_of(lk_addr);
        fwd_q     <= fill_acc & (idx_of(fill_addr) == idx_of(lk_addr));
        fwd_hit_q <= (tag_of(fill_addr) == tag_of(lk_addr));
      end
    end
  end

  assign ram_entry     = tag_entry_t'(tag_rd_data);
  assign lk_resp_valid = resp_valid_q;
  assign lk_hit        = resp_valid_q &
                         (fwd_q ? fwd_hit_q
                                : (ram_entry.valid & (ram_entry.tag == lk_tag_q)));

`ifdef ICACHE_TAG_PERF_CNT_EN
  // Saturating hit/miss counters, cleared on reset and on entering a sweep.
  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) begin
      perf_hit_cnt  <= '0;
      perf_miss_cnt <= '0;
    end else if (enter_sweep) begin
      perf_hit_cnt  <= '0;
      perf_miss_cnt <= '0;
    end else if (resp_valid_q) begin
      if (lk_hit && perf_hit_cnt != '1)   perf_hit_cnt  <= perf_hit_cnt + 32'd1;
      if (!lk_hit && perf_miss_cnt != '1) perf_miss_cnt <= perf_miss_cnt + 32'd1;
    end
  end
`else
  logic unused_enter_sweep;
  assign unused_enter_sweep = enter_sweep;
`endif

endmodule

// File: tb/tb_icache_tag_ctrl.sv
// Testbench for icache_tag_ctrl: bench-side tag RAM, a set-level reference
// model checked every cycle, directed scenarios with literal expectations
// and a randomized request phase.
module tb_icache_tag_ctrl;
  import icache_tag_pkg::*;

  logic        wr_clk = 1'b0;
  logic        tb_wr_rst = 1'b1;
  logic        lk_valid = 1'b0;
  logic [31:0] lk_addr = '0;
  logic        fill_valid = 1'b0;
  logic [31:0] fill_addr = '0;
  logic        flush_req = 1'b0;
  logic        lk_ready, lk_resp_valid, lk_hit, fill_ready;
  logic        flush_busy, flush_done, tag_wr_en;
  logic [7:0]  tag_wr_addr, tag_rd_addr;
  logic [20:0] tag_wr_data, tag_rd_data;
`ifdef ICACHE_TAG_PERF_CNT_EN
  logic [31:0] perf_hit_cnt, perf_miss_cnt;
`endif

  always #5 wr_clk = ~wr_clk;

  icache_tag_ctrl dut (
    .wr_clk        (wr_clk),
    .tb_wr_rst     (tb_wr_rst),
    .lk_valid      (lk_valid),
    .lk_ready      (lk_ready),
    .lk_addr       (lk_addr),
    .lk_resp_valid (lk_resp_valid),
    .lk_hit        (lk_hit),
    .fill_valid    (fill_valid),
    .fill_ready    (fill_ready),
    .fill_addr     (fill_addr),
    .flush_req     (flush_req),
    .flush_busy    (flush_busy),
    .flush_done    (flush_done),
    .tag_wr_en     (tag_wr_en),
    .tag_wr_addr   (tag_wr_addr),
    .tag_wr_data   (tag_wr_data),
    .tag_rd_addr   (tag_rd_addr),
    .tag_rd_data   (tag_rd_data)
`ifdef ICACHE_TAG_PERF_CNT_EN
    ,
    .perf_hit_cnt  (perf_hit_cnt),
    .perf_miss_cnt (perf_miss_cnt)
`endif
  );

  // Tag RAM: synchronous write, 1-cycle read, read-before-write; powers up
  // with garbage so only the sweep can make it clean.
  logic [20:0] ram [256];
  initial for (int i = 0; i < 256; i++) ram[i] = 21'($urandom);
  always @(posedge wr_clk) begin
    if (tag_wr_en) ram[tag_wr_addr] <= tag_wr_data;
    tag_rd_data <= ram[tag_rd_addr];
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-set valid/tag arrays, a sweep position, and the
  // response owed for the previous cycle's lookup.
  bit          m_busy = 1'b1;
  int          m_idx = 0;
  bit          m_done = 1'b0;
  bit          m_valid [256];
  logic [19:0] m_tag [256];
  bit          m_pend = 1'b0;
  bit          m_pend_hit = 1'b0;
  logic [7:0]  m_last_rd = '0;
  longint      m_hits = 0;
  longint      m_misses = 0;

  always @(negedge wr_clk) begin
    if (tb_wr_rst) begin
      check("rst_lk_ready", 64'(lk_ready), 64'(0));
      check("rst_fill_ready", 64'(fill_ready), 64'(0));
      check("rst_resp_valid", 64'(lk_resp_valid), 64'(0));
      check("rst_hit", 64'(lk_hit), 64'(0));
      check("rst_flush_busy", 64'(flush_busy), 64'(1));
      check("rst_flush_done", 64'(flush_done), 64'(0));
      check("rst_wr_en", 64'(tag_wr_en), 64'(0));
      check("rst_wr_addr", 64'(tag_wr_addr), 64'(0));
      check("rst_wr_data", 64'(tag_wr_data), 64'(0));
      check("rst_rd_addr", 64'(tag_rd_addr), 64'(0));
      m_busy = 1'b1; m_idx = 0; m_done = 1'b0; m_pend = 1'b0;
      m_last_rd = '0; m_hits = 0; m_misses = 0;
`ifdef ICACHE_TAG_PERF_CNT_EN
      check("rst_perf_hit", 64'(perf_hit_cnt), 64'(0));
      check("rst_perf_miss", 64'(perf_miss_cnt), 64'(0));
`endif
    end else begin
      bit          la, fa, exp_wr, new_hit;
      logic [7:0]  li, fi;
      logic [19:0] lt, ft;
      la = lk_valid && !m_busy;
      fa = fill_valid && !m_busy;
      li = 8'((lk_addr >> 4) % 256);
      fi = 8'((fill_addr >> 4) % 256);
      lt = 20'(lk_addr >> 12);
      ft = 20'(fill_addr >> 12);
      exp_wr = m_busy || fa;

      check("lk_ready", 64'(lk_ready), 64'(!m_busy));
      check("fill_ready", 64'(fill_ready), 64'(!m_busy));
      check("flush_busy", 64'(flush_busy), 64'(m_busy));
      check("flush_done", 64'(flush_done), 64'(m_done));
      check("resp_valid", 64'(lk_resp_valid), 64'(m_pend));
      if (m_pend) check("lk_hit", 64'(lk_hit), 64'(m_pend_hit));
      check("wr_en", 64'(tag_wr_en), 64'(exp_wr));
      if (m_busy) begin
        check("sweep_wr_addr", 64'(tag_wr_addr), 64'(m_idx));
        check("sweep_wr_data", 64'(tag_wr_data), 64'(0));
      end else if (fa) begin
        check("fill_wr_addr", 64'(tag_wr_addr), 64'(fi));
        check("fill_wr_data", 64'(tag_wr_data), 64'({1'b1, ft}));
      end
      check("rd_addr", 64'(tag_rd_addr), 64'(la ? li : m_last_rd));
`ifdef ICACHE_TAG_PERF_CNT_EN
      check("perf_hit", 64'(perf_hit_cnt), 64'(m_hits));
      check("perf_miss", 64'(perf_miss_cnt), 64'(m_misses));
`endif
      // Advance across the coming clock edge.
      if (!m_busy && flush_req) begin
        m_hits = 0; m_misses = 0;
      end else if (m_pend) begin
        if (m_pend_hit) m_hits++; else m_misses++;
      end
      new_hit = (fa && fi == li) ? (ft == lt) : (m_valid[li] && m_tag[li] == lt);
      m_pend = la;
      m_pend_hit = la && new_hit;
      if (la) m_last_rd = li;
      m_done = 1'b0;
      if (m_busy) begin
        m_valid[m_idx] = 1'b0;
        m_idx++;
        if (m_idx == 256) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end else begin
        if (fa) begin
          m_valid[fi] = 1'b1;
          m_tag[fi] = ft;
        end
        if (flush_req) begin
          m_busy = 1'b1;
          m_idx = 0;
        end
      end
    end
  end

  // Drive one cycle of inputs, just after the active edge.
  task automatic step(input bit lv, input logic [31:0] la, input bit fv,
                      input logic [31:0] fa, input bit fl);
    @(posedge wr_clk);
    #2;
    lk_valid = lv; lk_addr = la; fill_valid = fv; fill_addr = fa; flush_req = fl;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  // Check the response to the request driven in the previous step.
  task automatic expect_resp(input string name, input bit exp_hit);
    idle();
    @(negedge wr_clk);
    check({name, "_valid"}, 64'(lk_resp_valid), 64'(1));
    check(name, 64'(lk_hit), 64'(exp_hit));
  endtask

  task automatic lookup_expect(input string name, input logic [31:0] a, input bit exp_hit);
    step(1'b1, a, 1'b0, 32'h0, 1'b0);
    expect_resp(name, exp_hit);
  endtask

  task automatic fill(input logic [31:0] a);
    step(1'b0, 32'h0, 1'b1, a, 1'b0);
  endtask

  // Measure a sweep starting at the next falling edge (first SWEEP cycle).
  task automatic run_sweep(input string name, input bit second_flush);
    int n = 0;
    int d = 0;
    @(negedge wr_clk);
    check({name, "_lk_ready_low"}, 64'(lk_ready), 64'(0));
    while (flush_busy === 1'b1 && n < 1000) begin
      check({name, "_addr"}, 64'(tag_wr_addr), 64'(n));
      n++;
      if (flush_done === 1'b1) d++;
      if (second_flush && n == 50) #2 flush_req = 1'b1;
      if (second_flush && n == 51) #2 flush_req = 1'b0;
      @(negedge wr_clk);
    end
    if (flush_done === 1'b1) d++;
    check({name, "_cycles"}, 64'(n), 64'(256));
    check({name, "_done_now"}, 64'(flush_done), 64'(1));
    check({name, "_done_count"}, 64'(d), 64'(1));
    check({name, "_lk_ready_up"}, 64'(lk_ready), 64'(1));
  endtask

  task automatic start_flush(input string name);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    @(negedge wr_clk);
    check({name, "_ready_in_req_cycle"}, 64'(lk_ready), 64'(1));
    idle();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (flush_busy !== 1'b0 && n < 1000) begin
      idle();
      n++;
    end
    check("wait_idle_bound", 64'(n < 1000), 64'(1));
  endtask

  logic [19:0] tag_pool [4] = '{20'hABCDE, 20'h1BCDE, 20'h00000, 20'hFFFFF};
  logic [7:0]  idx_pool [8] = '{8'h00, 8'h12, 8'h35, 8'h36, 8'h77, 8'h80, 8'hFE, 8'hFF};

  function automatic logic [31:0] rand_addr();
    logic [19:0] t;
    logic [7:0]  i;
    t = tag_pool[$urandom_range(0, 3)];
    i = idx_pool[$urandom_range(0, 7)];
    return {t, i, 4'($urandom)};
  endfunction

  initial begin
    // Power-up reset, then the initial sweep.
    repeat (3) @(posedge wr_clk);
    #2 tb_wr_rst = 1'b0;
    run_sweep("init_sweep", 1'b0);

    // Directed lookups and fills.
    lookup_expect("cold_miss", 32'h0000_1230, 1'b0);
    fill(32'hABCD_E120);
    lookup_expect("fill_then_hit", 32'hABCD_E12C, 1'b1);
    lookup_expect("tag_mismatch", 32'h1BCD_E120, 1'b0);
    step(1'b1, 32'h0000_5340, 1'b1, 32'h0000_5340, 1'b0);
    expect_resp("fwd_hit", 1'b1);
    step(1'b1, 32'h0000_5350, 1'b1, 32'h0000_5360, 1'b0);
    expect_resp("diff_idx_ram", 1'b0);
    step(1'b1, 32'h0000_0120, 1'b1, 32'h0000_0120, 1'b0);
    expect_resp("fwd_over_ram", 1'b1);
    step(1'b1, 32'h0000_7770, 1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 32'h0000_7770, 1'b0);
    @(negedge wr_clk);
    check("late_fill_valid", 64'(lk_resp_valid), 64'(1));
    check("late_fill_no_effect", 64'(lk_hit), 64'(0));

    // Flush clears previously filled sets; a second request is ignored.
    fill(32'h0000_0100);
    fill(32'h0000_0200);
    lookup_expect("pre_flush_10", 32'h0000_0100, 1'b1);
    lookup_expect("pre_flush_20", 32'h0000_0200, 1'b1);
    start_flush("flush");
    run_sweep("flush_sweep", 1'b1);
    lookup_expect("post_flush_10", 32'h0000_0100, 1'b0);
    lookup_expect("post_flush_20", 32'h0000_0200, 1'b0);

    // Reset in the middle of a sweep.
    begin
      int n = 0;
      start_flush("rst_flush");
      @(negedge wr_clk);
      while (tag_wr_addr !== 8'd100 && n < 400) begin
        n++;
        @(negedge wr_clk);
      end
      check("reach_idx_100", 64'(tag_wr_addr), 64'(100));
      #1 tb_wr_rst = 1'b1;
      #1;
      check("midrst_wr_en", 64'(tag_wr_en), 64'(0));
      check("midrst_wr_addr", 64'(tag_wr_addr), 64'(0));
      check("midrst_busy", 64'(flush_busy), 64'(1));
      repeat (2) @(posedge wr_clk);
      #2 tb_wr_rst = 1'b0;
      run_sweep("rst_sweep", 1'b0);
    end

    // Randomized traffic checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      step(1'($urandom_range(0, 1)), rand_addr(),
           ($urandom_range(0, 2) == 0), rand_addr(),
           ($urandom_range(0, 299) == 0));
    end
    idle();
    wait_idle();

`ifdef ICACHE_TAG_PERF_CNT_EN
    start_flush("perf_flush");
    run_sweep("perf_sweep", 1'b0);
    fill(32'h0ABC_D450);
    lookup_expect("perf_h1", 32'h0ABC_D450, 1'b1);
    lookup_expect("perf_h2", 32'h0ABC_D454, 1'b1);
    lookup_expect("perf_h3", 32'h0ABC_D458, 1'b1);
    lookup_expect("perf_m1", 32'h1ABC_D450, 1'b0);
    lookup_expect("perf_m2", 32'h0ABC_D460, 1'b0);
    idle();
    @(negedge wr_clk);
    check("perf_hit_cnt", 64'(perf_hit_cnt), 64'(3));
    check("perf_miss_cnt", 64'(perf_miss_cnt), 64'(2));
`endif

    idle();
    @(negedge wr_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/icache_tag_ctrl.md
Name: icache_tag_ctrl

Overview:
Sequencer and port owner for the 256x21 instruction-cache tag SDP RAM (1-cycle read, no output register). It accepts lookups on the RAM read port and line fills on the write port. It performs a full-array invalidate sweep after reset and on software flush requests. It returns hit/miss one cycle after each accepted lookup.

Parameters:
IDX_W, 8, tag RAM index width (number of sets = 2**IDX_W)
TAG_W, 20, stored tag width; RAM word = {valid, tag} = TAG_W+1 = 21 bits
OFS_W, 4, line-offset bits (16-byte line); address split = {tag[31:12], idx[11:4], ofs[3:0]}

Ports:
wr_clk  in  1  clock for the controller and both RAM ports
tb_wr_rst  in  1  reset, asynchronous, active-high
lk_valid  in  1  lookup request
lk_ready  out  1  lookup accepted when lk_valid&lk_ready
lk_addr  in  32  lookup fetch address
lk_resp_valid  out  1  response strobe, 1 cycle after accept
lk_hit  out  1  hit flag, qualified by lk_resp_valid
fill_valid  in  1  fill request (write valid tag)
fill_ready  out  1  fill accepted when fill_valid&fill_ready
fill_addr  in  32  address whose line is being filled
flush_req  in  1  start full invalidate (level or pulse)
flush_busy  out  1  sweep in progress
flush_done  out  1  one-cycle pulse when the sweep completes
tag_wr_en  out  1  RAM write enable
tag_wr_addr  out  IDX_W  RAM write index
tag_wr_data  out  TAG_W+1  RAM write word
tag_rd_addr  out  IDX_W  RAM read index
tag_rd_data  in  TAG_W+1  RAM read word, valid 1 cycle after tag_rd_addr

Behaviour:
- Reset (tb_wr_rst, asynchronous, active-high, clock wr_clk): state=SWEEP, sweep counter=0.
- Output reset values: lk_ready=0, fill_ready=0, lk_resp_valid=0, lk_hit=0, flush_busy=1, flush_done=0, tag_wr_en=0, tag_wr_addr=0, tag_wr_data=0, tag_rd_addr=0.
- FSM states: SWEEP, IDLE.
- SWEEP:
  - tag_wr_en=1, tag_wr_addr=counter, tag_wr_data=0; counter increments every cycle.
  - lk_ready=0, fill_ready=0.
  - At counter=2**IDX_W-1 the FSM moves to IDLE next cycle. flush_done pulses in that first IDLE cycle, and flush_busy falls at the same time.
  - The sweep lasts exactly 256 write cycles.
- IDLE:
  - lk_ready=1 and fill_ready=1, both combinationally from state.
  - flush_req=1 in IDLE: next cycle is SWEEP with counter=0. In that same IDLE cycle lk_ready and fill_ready are still 1, and any request accepted in that cycle completes normally.
  - flush_req during SWEEP is ignored. There is no queuing and no restart.
- Lookup:
  - On accept, tag_rd_addr=lk_addr[11:4] combinationally, and lk_addr[31:12] is registered.
  - Next cycle: lk_resp_valid=1, lk_hit = tag_rd_data[20] & (tag_rd_data[19:0]==registered tag).
  - Throughput is one lookup per cycle with back-to-back accepts.
  - When no lookup is accepted, tag_rd_addr holds its last value.
- Fill:
  - On accept, tag_wr_en=1, tag_wr_addr=fill_addr[11:4], tag_wr_data={1'b1, fill_addr[31:12]}, all combinational in that cycle.
  - No response is returned for a fill.
- Write/read hazard:
  - If a fill and a lookup are accepted in the same cycle with the same index, the lookup result uses the fill word, not tag_rd_data.
  - The forwarding is registered compare logic: a fill to index 0x12 with a lookup of the same tag/index in the same cycle gives hit=1.
- A fill in the cycle after a lookup to the same index does not affect that lookup. The lookup reports the pre-fill contents.
- Tag RAM contents are not affected by reset. The post-reset SWEEP is the only initialisation.
- Reset asserted mid-sweep or mid-lookup: all outputs return to their reset values immediately, any pending response is dropped, and the sweep restarts from index 0 on release.

Optional Feature:
- Macro: ICACHE_TAG_PERF_CNT_EN.
- When defined:
  - Adds output ports perf_hit_cnt[31:0] and perf_miss_cnt[31:0].
  - These count lk_resp_valid with lk_hit=1 and lk_hit=0 respectively.
  - Each counter saturates at 0xFFFFFFFF.
  - Both counters clear on tb_wr_rst and on entry to SWEEP.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package icache_tag_pkg holds:
  - localparams IDX_W, TAG_W, OFS_W and TAG_WORD_W=TAG_W+1.
  - The state enum {SWEEP, IDLE}.
  - A packed tag-entry type {valid, tag}.
  - Address slice helper functions idx_of(addr) and tag_of(addr).
- One sub-module is natural: icache_tag_sweep, the index counter with last-index detect and the done pulse. The lookup/hazard logic stays in the top.

Test Plan:
- Release reset -> flush_busy=1 for 256 cycles with tag_wr_addr stepping 0..255 and tag_wr_data=0; flush_done pulses once; lk_ready rises in the same cycle.
- After the sweep, lookup 0x0000_1230 -> one cycle later lk_resp_valid=1, lk_hit=0.
- Fill 0xABCD_E120, then on the next cycle lookup 0xABCD_E12C -> lk_hit=1. Lookup 0x1BCD_E120 (same index, different tag) -> lk_hit=0.
- Fill 0x0000_5340 and lookup 0x0000_5340 in the same cycle -> lk_hit=1 via forwarding. The same pair with different indices -> lk_hit comes from RAM, giving 0.
- Assert flush_req after filling indexes 0x10 and 0x20 -> lk_ready=0 for 256 cycles; afterwards, lookups of both addresses -> lk_hit=0. A second flush_req during the sweep produces only one flush_done.
- Assert reset at sweep index 100 -> outputs return to reset values; after release the sweep restarts at index 0 and takes a full 256 cycles. With ICACHE_TAG_PERF_CNT_EN defined, 3 hits and 2 misses -> perf_hit_cnt=3, perf_miss_cnt=2.
